// File: rtl/eth_udp_recv_if.sv
// eth_udp_recv_if: MII receive nibble stream in, UDP payload byte stream out.
interface eth_udp_recv_if;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  logic              rx_stb;
  logic              rx_dv;
  logic [NIB_W-1:0]  rx_d;
  logic [BYTE_W-1:0] d;
  logic              d_valid;
  logic              d_last;

  // PHY/stimulus side drives nibbles and consumes payload bytes
  modport master (output rx_stb, rx_dv, rx_d, input d, d_valid, d_last);
  // Receiver side
  modport slave  (input rx_stb, rx_dv, rx_d, output d, d_valid, d_last);
endinterface

// File: rtl/eth_udp_recv.sv
// eth_udp_recv: strips preamble/SFD from the MII nibble stream, filters the
// Ethernet II / IPv4 / UDP headers against local_mac/ip/port and streams the
// UDP payload with a per-frame accept/reject pulse.
// Optional FCS check is enabled by defining ETH_UDP_RECV_CRC_EN.
module eth_udp_recv #(
  parameter bit          ACCEPT_BROADCAST     = 1'b1,
  parameter int unsigned MIN_PREAMBLE_NIBBLES = 1
) (
  input  logic          clk,
  input  logic          rstn,
  eth_udp_recv_if.slave bus,
  input  logic [47:0]   local_mac,
  input  logic [31:0]   local_ip,
  input  logic [15:0]   local_port,
  output logic [47:0]   src_mac,
  output logic [31:0]   src_ip,
  output logic [15:0]   src_port,
  output logic          frame_ok,
  output logic          frame_err,
  output logic          busy
);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned PRE_W = 5;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_PAD, S_DROP
  } state_t;

  state_t             r_state, w_state_nx;
  logic               r_armed;
  logic [PRE_W-1:0]   r_pre_cnt;
  logic               r_phase;
  logic [3:0]         r_lo;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ucast, r_bcast;
  logic [47:0]        r_sh_mac;
  logic [31:0]        r_sh_ip;
  logic [15:0]        r_sh_port;
  logic [LEN_W-1:0]   r_len, r_rem;
  logic [7:0]         r_d;
  logic               r_d_valid, r_d_last, r_frame_ok, r_frame_err, r_busy;
  logic [47:0]        r_src_mac;
  logic [31:0]        r_src_ip;
  logic [15:0]        r_src_port;

  logic        w_nib, w_end, w_assembling, w_byte_done, w_hdr_byte, w_start, w_sfd;
  logic [7:0]  w_byte;
  logic [47:0] w_mac_sh;
  logic [31:0] w_ip_sh;
  logic [1:0]  w_ip_off;
  logic [7:0]  w_port_byte;
  logic        w_ucast, w_bcast, w_hdr_fail, w_crc_ok;
  logic        w_emit, w_last, w_ok, w_err;

  assign w_nib        = bus.rx_stb && bus.rx_dv;
  assign w_end        = bus.rx_stb && !bus.rx_dv;
  assign w_byte       = {bus.rx_d, r_lo};
  assign w_assembling = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_PAD);
  assign w_byte_done  = w_nib && r_phase && w_assembling;
  assign w_hdr_byte   = w_byte_done && (r_state == S_HEADER);
  assign w_start      = (r_state == S_IDLE) && w_nib && r_armed && (bus.rx_d == 4'h5);
  assign w_sfd        = (r_state == S_PREAMBLE) && w_nib && (bus.rx_d == 4'hD) &&
                        ({27'd0, r_pre_cnt} >= MIN_PREAMBLE_NIBBLES);

  assign w_mac_sh    = local_mac << {r_idx[2:0], 3'b000};
  assign w_ip_off    = 2'(r_idx - 6'd30);
  assign w_ip_sh     = local_ip << {w_ip_off, 3'b000};
  assign w_port_byte = r_idx[0] ? local_port[7:0] : local_port[15:8];

`ifdef ETH_UDP_RECV_CRC_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // Reflected CRC-32 over every byte from dst MAC through FCS
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_crc <= '0;
    else if (w_sfd)       r_crc <= '1;
    else if (w_byte_done) r_crc <= crc_step(r_crc, w_byte);
  end
  assign w_crc_ok = (r_crc == CRC_RESIDUE);
`else
  assign w_crc_ok = 1'b1;
`endif

  // Header byte filter for the byte completing this strobe
  always_comb begin
    w_ucast    = 1'b0;
    w_bcast    = 1'b0;
    w_hdr_fail = 1'b0;
    if (r_idx <= 6'd5) begin
      w_ucast    = ((r_idx == '0) || r_ucast) && (w_byte == w_mac_sh[47:40]);
      w_bcast    = ACCEPT_BROADCAST && ((r_idx == '0) || r_bcast) && (w_byte == 8'hFF);
      w_hdr_fail = !(w_ucast || w_bcast);
    end else begin
      case (r_idx)
        6'd12:                      w_hdr_fail = (w_byte != 8'h08);
        6'd13:                      w_hdr_fail = (w_byte != 8'h00);
        6'd14:                      w_hdr_fail = (w_byte != 8'h45);
        6'd23:                      w_hdr_fail = (w_byte != 8'h11);
        6'd30, 6'd31, 6'd32, 6'd33: w_hdr_fail = (w_byte != w_ip_sh[31:24]);
        6'd36, 6'd37:               w_hdr_fail = (w_byte != w_port_byte);
        6'd39:                      w_hdr_fail = ({r_len[7:0], w_byte} < 16'd8);
        default:                    w_hdr_fail = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic; every transition is qualified by rx_stb
  always_comb begin
    w_state_nx = r_state;
    if (bus.rx_stb) begin
      case (r_state)
        S_IDLE:     if (bus.rx_dv && r_armed) w_state_nx = (bus.rx_d == 4'h5) ? S_PREAMBLE : S_DROP;
        S_PREAMBLE: if (!bus.rx_dv)             w_state_nx = S_IDLE;
                    else if (w_sfd)             w_state_nx = S_HEADER;
                    else if (bus.rx_d != 4'h5)  w_state_nx = S_DROP;
        S_HEADER:   if (!bus.rx_dv)             w_state_nx = S_IDLE;
                    else if (w_hdr_byte) begin
                      if (w_hdr_fail)           w_state_nx = S_DROP;
                      else if (r_idx == 6'd41)  w_state_nx = (r_len == 16'd8) ? S_PAD : S_PAYLOAD;
                    end
        S_PAYLOAD:  if (!bus.rx_dv)             w_state_nx = S_IDLE;
                    else if (w_byte_done && (r_rem == 16'd1)) w_state_nx = S_PAD;
        S_PAD,
        S_DROP:     if (!bus.rx_dv)             w_state_nx = S_IDLE;
        default:                                w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output decode: payload emission and end-of-frame verdict
  always_comb begin
    w_emit = 1'b0;
    w_last = 1'b0;
    w_ok   = 1'b0;
    w_err  = 1'b0;
    if ((r_state == S_PAYLOAD) && w_byte_done) begin
      w_emit = 1'b1;
      w_last = (r_rem == 16'd1);
    end
    if (w_end) begin
      if (r_state == S_PAD) begin
        w_ok  = !r_phase && w_crc_ok;
        w_err = !w_ok;
      end else if (r_state == S_PAYLOAD) begin
        w_err = 1'b1;
      end
    end
  end

  // Datapath: nibble assembly, header shadows, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_armed     <= 1'b0;
      r_pre_cnt   <= '0;
      r_phase     <= 1'b0;
      r_lo        <= '0;
      r_idx       <= '0;
      r_ucast     <= 1'b0;
      r_bcast     <= 1'b0;
      r_sh_mac    <= '0;
      r_sh_ip     <= '0;
      r_sh_port   <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_d_valid   <= 1'b0;
      r_d_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_src_mac   <= '0;
      r_src_ip    <= '0;
      r_src_port  <= '0;
    end else begin
      r_d_valid   <= w_emit;
      r_d_last    <= w_last;
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      r_busy      <= (w_state_nx != S_IDLE);
      if (w_emit) r_d <= w_byte;
      if (w_end)  r_armed <= 1'b1;

      if (w_start) r_pre_cnt <= PRE_W'(1);
      else if ((r_state == S_PREAMBLE) && w_nib && (bus.rx_d == 4'h5) && (r_pre_cnt != '1))
        r_pre_cnt <= r_pre_cnt + PRE_W'(1);

      if (w_sfd || w_end) r_phase <= 1'b0;
      else if (w_nib && w_assembling) begin
        r_phase <= !r_phase;
        if (!r_phase) r_lo <= bus.rx_d;
      end

      if (w_sfd) r_idx <= '0;
      else if (w_hdr_byte) begin
        r_idx   <= r_idx + IDX_W'(1);
        r_ucast <= w_ucast;
        r_bcast <= w_bcast;
        if ((r_idx >= 6'd6) && (r_idx <= 6'd11))  r_sh_mac  <= {r_sh_mac[39:0], w_byte};
        if ((r_idx >= 6'd26) && (r_idx <= 6'd29)) r_sh_ip   <= {r_sh_ip[23:0], w_byte};
        if ((r_idx == 6'd34) || (r_idx == 6'd35)) r_sh_port <= {r_sh_port[7:0], w_byte};
        if ((r_idx == 6'd38) || (r_idx == 6'd39)) r_len     <= {r_len[7:0], w_byte};
        if (r_idx == 6'd41)                       r_rem     <= r_len - LEN_W'(8);
      end else if (w_emit) begin
        r_rem <= r_rem - LEN_W'(1);
      end

      if (w_ok) begin
        r_src_mac  <= r_sh_mac;
        r_src_ip   <= r_sh_ip;
        r_src_port <= r_sh_port;
      end
    end
  end

  assign bus.d       = r_d;
  assign bus.d_valid = r_d_valid;
  assign bus.d_last  = r_d_last;
  assign frame_ok    = r_frame_ok;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;
  assign src_mac     = r_src_mac;
  assign src_ip      = r_src_ip;
  assign src_port    = r_src_port;
endmodule

// File: tb/tb_eth_udp_recv.sv
// tb_eth_udp_recv: directed frames into two receivers (broadcast on, min
// preamble 1 / broadcast off, min preamble 4) with hand-computed expectations.
module tb_eth_udp_recv;
  localparam logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LOCAL_IP   = 32'hC0A8_010A;
  localparam logic [15:0] LOCAL_PORT = 16'h1234;
  localparam logic [47:0] SRC_A      = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC_B      = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] BCAST      = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] SRC_IP     = 32'hC0A8_0164;

  logic       clk;
  logic       rstn;
  logic       rx_stb;
  logic       rx_dv;
  logic [3:0] rx_d;

  logic [47:0] src_mac0, src_mac1;
  logic [31:0] src_ip0, src_ip1;
  logic [15:0] src_port0, src_port1;
  logic        frame_ok0, frame_err0, busy0, frame_ok1, frame_err1, busy1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fr[$];
  logic [7:0] mon_b[$];
  int  n_last = 0, last_pos = -1, ok0 = 0, err0 = 0, ok1 = 0, err1 = 0, dv1 = 0;
  bit  both_high = 1'b0;
  int  s_b, s_last, s_ok0, s_err0, s_ok1, s_err1, s_dv1;

  eth_udp_recv_if bus0();
  eth_udp_recv_if bus1();
  assign bus0.rx_stb = rx_stb;
  assign bus0.rx_dv  = rx_dv;
  assign bus0.rx_d   = rx_d;
  assign bus1.rx_stb = rx_stb;
  assign bus1.rx_dv  = rx_dv;
  assign bus1.rx_d   = rx_d;

  eth_udp_recv #(.ACCEPT_BROADCAST(1'b1), .MIN_PREAMBLE_NIBBLES(1)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus0),
    .local_mac(LOCAL_MAC), .local_ip(LOCAL_IP), .local_port(LOCAL_PORT),
    .src_mac(src_mac0), .src_ip(src_ip0), .src_port(src_port0),
    .frame_ok(frame_ok0), .frame_err(frame_err0), .busy(busy0));

  eth_udp_recv #(.ACCEPT_BROADCAST(1'b0), .MIN_PREAMBLE_NIBBLES(4)) u_dut_nb (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .local_mac(LOCAL_MAC), .local_ip(LOCAL_IP), .local_port(LOCAL_PORT),
    .src_mac(src_mac1), .src_ip(src_ip1), .src_port(src_port1),
    .frame_ok(frame_ok1), .frame_err(frame_err1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output recorder, sampled away from the active edge
  always @(negedge clk) begin
    if (bus0.d_valid) begin
      mon_b.push_back(bus0.d);
      if (bus0.d_last) begin
        n_last++;
        last_pos = mon_b.size() - 1;
      end
    end
    if (frame_ok0)  ok0++;
    if (frame_err0) err0++;
    if (frame_ok1)  ok1++;
    if (frame_err1) err1++;
    if (bus1.d_valid) dv1++;
    if ((frame_ok0 && frame_err0) || (frame_ok1 && frame_err1)) both_high = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      if (x[0] ^ b[i]) x = (x >> 1) ^ 32'hEDB88320;
      else             x = x >> 1;
    end
    return x;
  endfunction

  function automatic logic [8:0] got_byte(input int idx);
    if (idx < mon_b.size()) return {1'b0, mon_b[idx]};
    return 9'h100;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] sport,
                             input logic [15:0] dport, input logic [15:0] ulen,
                             input int npay, input logic [31:0] pay);
    logic [31:0] crc;
    logic [15:0] iplen;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'(dst >> (8 * (5 - i))));
    for (int i = 0; i < 6; i++) fr.push_back(8'(src >> (8 * (5 - i))));
    fr.push_back(8'h08); fr.push_back(8'h00);
    iplen = 16'd20 + ulen;
    fr.push_back(8'h45); fr.push_back(8'h00); fr.push_back(iplen[15:8]); fr.push_back(iplen[7:0]);
    for (int i = 0; i < 4; i++) fr.push_back(8'h00);
    fr.push_back(8'h40); fr.push_back(8'h11); fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < 4; i++) fr.push_back(8'(SRC_IP >> (8 * (3 - i))));
    for (int i = 0; i < 4; i++) fr.push_back(8'(LOCAL_IP >> (8 * (3 - i))));
    fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
    fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
    fr.push_back(ulen[15:8]);  fr.push_back(ulen[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < npay; i++) fr.push_back(8'(pay >> (8 * (3 - i))));
    while (fr.size() < 60) fr.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < fr.size(); i++) crc = crc_byte(crc, fr[i]);
    crc = ~crc;
    fr.push_back(crc[7:0]); fr.push_back(crc[15:8]); fr.push_back(crc[23:16]); fr.push_back(crc[31:24]);
  endtask

  task automatic strobe(input logic dv, input logic [3:0] nib);
    @(posedge clk); #1;
    rx_stb = 1'b1; rx_dv = dv; rx_d = nib;
    @(posedge clk); #1;
    rx_stb = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic snap();
    s_b = mon_b.size(); s_last = n_last; s_ok0 = ok0; s_err0 = err0;
    s_ok1 = ok1; s_err1 = err1; s_dv1 = dv1;
  endtask

  task automatic send_pre(input int npre);
    for (int i = 0; i < npre; i++) strobe(1'b1, 4'h5);
    strobe(1'b1, 4'hD);
  endtask

  task automatic send_bytes(input int from, input int to);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = fr[i];
      strobe(1'b1, b[3:0]);
      strobe(1'b1, b[7:4]);
    end
  endtask

  task automatic send_end();
    strobe(1'b0, 4'h0);
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input int npre, input int nbytes);
    snap();
    send_pre(npre);
    send_bytes(0, nbytes);
    send_end();
  endtask

  initial begin
    rstn = 1'b0; rx_stb = 1'b0; rx_dv = 1'b0; rx_d = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      64'(busy0), 64'd0);
    check("rst_d_valid",   64'(bus0.d_valid), 64'd0);
    check("rst_frame_ok",  64'(frame_ok0), 64'd0);
    check("rst_frame_err", 64'(frame_err0), 64'd0);
    check("rst_src_mac",   64'(src_mac0), 64'd0);
    check("rst_src_ip",    64'(src_ip0), 64'd0);
    check("rst_src_port",  64'(src_port0), 64'd0);
    rstn = 1'b1;
    strobe(1'b0, 4'h0);
    strobe(1'b0, 4'h0);

    // Good frame, payload DE AD BE EF
    build_frame(LOCAL_MAC, SRC_A, 16'hABCD, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    send_frame(15, fr.size());
    check("good_nbytes", 64'(mon_b.size() - s_b), 64'd4);
    check("good_b0", 64'(got_byte(s_b)),     64'h0DE);
    check("good_b1", 64'(got_byte(s_b + 1)), 64'h0AD);
    check("good_b2", 64'(got_byte(s_b + 2)), 64'h0BE);
    check("good_b3", 64'(got_byte(s_b + 3)), 64'h0EF);
    check("good_nlast",   64'(n_last - s_last), 64'd1);
    check("good_lastpos", 64'(last_pos), 64'(s_b + 3));
    check("good_ok",      64'(ok0 - s_ok0), 64'd1);
    check("good_err",     64'(err0 - s_err0), 64'd0);
    check("good_src_mac", 64'(src_mac0), 64'(SRC_A));
    check("good_src_ip",  64'(src_ip0), 64'(SRC_IP));
    check("good_src_port", 64'(src_port0), 64'hABCD);
    check("good_ok_inst1", 64'(ok1 - s_ok1), 64'd1);

    // Wrong destination port: silent drop, then a good frame is accepted
    build_frame(LOCAL_MAC, SRC_B, 16'h1111, 16'h1235, 16'd12, 4, 32'hDEADBEEF);
    send_frame(15, fr.size());
    check("port_nbytes", 64'(mon_b.size() - s_b), 64'd0);
    check("port_ok",     64'(ok0 - s_ok0), 64'd0);
    check("port_err",    64'(err0 - s_err0), 64'd0);
    check("port_src_mac", 64'(src_mac0), 64'(SRC_A));
    check("port_src_port", 64'(src_port0), 64'hABCD);
    build_frame(LOCAL_MAC, SRC_B, 16'h1111, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    send_frame(15, fr.size());
    check("next_ok",       64'(ok0 - s_ok0), 64'd1);
    check("next_src_mac",  64'(src_mac0), 64'(SRC_B));
    check("next_src_port", 64'(src_port0), 64'h1111);

    // Broadcast destination
    build_frame(BCAST, SRC_B, 16'h1111, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    send_frame(15, fr.size());
    check("bcast_ok",     64'(ok0 - s_ok0), 64'd1);
    check("bcast_nbytes", 64'(mon_b.size() - s_b), 64'd4);
    check("nobcast_ok",   64'(ok1 - s_ok1), 64'd0);
    check("nobcast_err",  64'(err1 - s_err1), 64'd0);
    check("nobcast_dv",   64'(dv1 - s_dv1), 64'd0);

    // rx_dv drops after 2 of 4 payload bytes
    build_frame(LOCAL_MAC, SRC_A, 16'hABCD, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    send_frame(15, 44);
    check("trunc_nbytes", 64'(mon_b.size() - s_b), 64'd2);
    check("trunc_nlast",  64'(n_last - s_last), 64'd0);
    check("trunc_err",    64'(err0 - s_err0), 64'd1);
    check("trunc_ok",     64'(ok0 - s_ok0), 64'd0);

    // Payload bit flipped after the FCS was computed
    build_frame(LOCAL_MAC, SRC_A, 16'hABCD, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    fr[45] = fr[45] ^ 8'h01;
    send_frame(15, fr.size());
    check("flip_nbytes", 64'(mon_b.size() - s_b), 64'd4);
    check("flip_b3",     64'(got_byte(s_b + 3)), 64'h0EE);
`ifdef ETH_UDP_RECV_CRC_EN
    check("flip_err",     64'(err0 - s_err0), 64'd1);
    check("flip_ok",      64'(ok0 - s_ok0), 64'd0);
    check("flip_src_mac", 64'(src_mac0), 64'(SRC_B));
`else
    check("flip_err",     64'(err0 - s_err0), 64'd0);
    check("flip_ok",      64'(ok0 - s_ok0), 64'd1);
    check("flip_src_mac", 64'(src_mac0), 64'(SRC_A));
`endif

    // UDP length 8: no payload, still accepted
    build_frame(LOCAL_MAC, SRC_B, 16'h2222, LOCAL_PORT, 16'd8, 0, 32'h0);
    send_frame(15, fr.size());
    check("l8_ok",     64'(ok0 - s_ok0), 64'd1);
    check("l8_nbytes", 64'(mon_b.size() - s_b), 64'd0);
    check("l8_src_port", 64'(src_port0), 64'h2222);

    // UDP length 7: malformed, silent drop
    build_frame(LOCAL_MAC, SRC_A, 16'h3333, LOCAL_PORT, 16'd7, 0, 32'h0);
    send_frame(15, fr.size());
    check("l7_ok",  64'(ok0 - s_ok0), 64'd0);
    check("l7_err", 64'(err0 - s_err0), 64'd0);
    check("l7_src_port", 64'(src_port0), 64'h2222);

    // Preamble length boundaries (instance 1 needs 4 nibbles)
    build_frame(LOCAL_MAC, SRC_A, 16'hABCD, LOCAL_PORT, 16'd12, 4, 32'h01020304);
    send_frame(1, fr.size());
    check("pre1_ok_inst0", 64'(ok0 - s_ok0), 64'd1);
    check("pre1_ok_inst1", 64'(ok1 - s_ok1), 64'd0);
    check("pre1_err_inst1", 64'(err1 - s_err1), 64'd0);
    send_frame(4, fr.size());
    check("pre4_ok_inst1", 64'(ok1 - s_ok1), 64'd1);

    // Reset at header byte 20 with rx_dv held high
    build_frame(LOCAL_MAC, SRC_B, 16'h4444, LOCAL_PORT, 16'd12, 4, 32'hDEADBEEF);
    snap();
    send_pre(15);
    send_bytes(0, 21);
    check("mid_busy", 64'(busy0), 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy",    64'(busy0), 64'd0);
    check("mid_rst_src_mac", 64'(src_mac0), 64'd0);
    check("mid_rst_src_port", 64'(src_port0), 64'd0);
    check("mid_rst_ok",      64'(frame_ok0), 64'd0);
    check("mid_rst_dvalid",  64'(bus0.d_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_bytes(21, fr.size());
    check("tail_busy",   64'(busy0), 64'd0);
    check("tail_nbytes", 64'(mon_b.size() - s_b), 64'd0);
    send_end();
    check("tail_ok",  64'(ok0 - s_ok0), 64'd0);
    check("tail_err", 64'(err0 - s_err0), 64'd0);
    send_frame(15, fr.size());
    check("after_rst_ok",       64'(ok0 - s_ok0), 64'd1);
    check("after_rst_src_mac",  64'(src_mac0), 64'(SRC_B));
    check("after_rst_src_port", 64'(src_port0), 64'h4444);

    check("ok_err_exclusive", 64'(both_high), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
